// File: rtl/flag_unit_if.sv
// Control, ALU-flag and status signals of the flag unit, bundled between the
// sequencer (master) and flag_unit (slave). The 8-bit system bus stays on plain ports.
interface flag_unit_if;
  logic       i_flagNegative;
  logic       i_flagZero;
  logic       i_flagOverflow;
  logic       i_flagCarry;
  logic       i_ctrlFlagsNWE;
  logic       i_ctrlFlagsBusNWE;
  logic       i_ctrlFlagsNOE;
  logic       i_ctrlPush;
  logic       i_ctrlPop;
  logic       i_ctrlEval;
  logic [3:0] i_cond;
  logic       o_flagNegative;
  logic       o_flagZero;
  logic       o_flagOverflow;
  logic       o_flagCarry;
  logic       o_condTrue;
  logic       o_stackFull;
  logic       o_stackEmpty;
  logic       o_stackError;

  // Strobe semantics: every control input is sampled on each rising i_clk edge;
  // there is no valid/ready handshake, so the unit always accepts and status
  // outputs are valid one edge after the strobe that caused them.
  modport master (
    output i_flagNegative, i_flagZero, i_flagOverflow, i_flagCarry,
           i_ctrlFlagsNWE, i_ctrlFlagsBusNWE, i_ctrlFlagsNOE,
           i_ctrlPush, i_ctrlPop, i_ctrlEval, i_cond,
    input  o_flagNegative, o_flagZero, o_flagOverflow, o_flagCarry,
           o_condTrue, o_stackFull, o_stackEmpty, o_stackError
  );

  modport slave (
    input  i_flagNegative, i_flagZero, i_flagOverflow, i_flagCarry,
           i_ctrlFlagsNWE, i_ctrlFlagsBusNWE, i_ctrlFlagsNOE,
           i_ctrlPush, i_ctrlPop, i_ctrlEval, i_cond,
    output o_flagNegative, o_flagZero, o_flagOverflow, o_flagCarry,
           o_condTrue, o_stackFull, o_stackEmpty, o_stackError
  );
endinterface

// File: rtl/flag_unit.sv
// CPU flag register {N,Z,V,C} with bus/ALU load, a 4-deep LIFO flag stack
// and a registered branch-condition evaluator.
module flag_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  flag_unit_if.slave  ctl,
  input  logic [7:0]  i_bus,
  output logic [7:0]  o_bus
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [3:0] stack_q [4];
  logic [2:0] depth_q;
  logic [2:0] depth_d;
  logic       cond_true_q;
  logic       stack_error_q;

  logic       full;
  logic       empty;
  logic       push_ok;
  logic       pop_ok;
  logic       err_evt;
  logic [1:0] push_idx;
  logic [1:0] top_idx;
  logic       cond_val;

  assign full     = (depth_q == 3'd4);
  assign empty    = (depth_q == 3'd0);
  assign push_idx = depth_q[1:0];
  assign top_idx  = push_idx - 2'd1;

  // Simultaneous push and pop is treated as an error and touches neither stack nor flags.
  assign push_ok = ctl.i_ctrlPush && !ctl.i_ctrlPop && !full;
  assign pop_ok  = ctl.i_ctrlPop && !ctl.i_ctrlPush && !empty;
  assign err_evt = (ctl.i_ctrlPush && ctl.i_ctrlPop) ||
                   (ctl.i_ctrlPush && !ctl.i_ctrlPop && full) ||
                   (ctl.i_ctrlPop && !ctl.i_ctrlPush && empty);

  always_comb begin
    flags_d = flags_q;
    if (pop_ok)
      flags_d = stack_q[top_idx];
    else if (!ctl.i_ctrlFlagsBusNWE)
      flags_d = i_bus[3:0];
    else if (!ctl.i_ctrlFlagsNWE)
      flags_d = {ctl.i_flagNegative, ctl.i_flagZero, ctl.i_flagOverflow, ctl.i_flagCarry};
  end

  always_comb begin
    depth_d = depth_q;
    if (push_ok)
      depth_d = depth_q + 3'd1;
    else if (pop_ok)
      depth_d = depth_q - 3'd1;
  end

  always_comb begin
    logic n, z, v, c;
    n = flags_q[3];
    z = flags_q[2];
    v = flags_q[1];
    c = flags_q[0];
    cond_val = 1'b0;
    case (ctl.i_cond)
      4'd0:  cond_val = 1'b1;
      4'd1:  cond_val = z;
      4'd2:  cond_val = !z;
      4'd3:  cond_val = c;
      4'd4:  cond_val = !c;
      4'd5:  cond_val = n;
      4'd6:  cond_val = !n;
      4'd7:  cond_val = v;
      4'd8:  cond_val = !v;
      4'd9:  cond_val = c && !z;
      4'd10: cond_val = !c || z;
      4'd11: cond_val = (n == v);
      4'd12: cond_val = (n != v);
      4'd13: cond_val = !z && (n == v);
      4'd14: cond_val = z || (n != v);
      default: cond_val = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      flags_q       <= 4'h0;
      depth_q       <= 3'd0;
      cond_true_q   <= 1'b0;
      stack_error_q <= 1'b0;
      for (int i = 0; i < 4; i++) stack_q[i] <= 4'h0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      if (push_ok)
        stack_q[push_idx] <= flags_q;
      if (ctl.i_ctrlEval)
        cond_true_q <= cond_val;
      if (err_evt)
        stack_error_q <= 1'b1;
    end
  end

  assign o_bus = ctl.i_ctrlFlagsNOE ? 8'hzz : {4'b0000, flags_q};

  assign ctl.o_flagNegative = flags_q[3];
  assign ctl.o_flagZero     = flags_q[2];
  assign ctl.o_flagOverflow = flags_q[1];
  assign ctl.o_flagCarry    = flags_q[0];
  assign ctl.o_condTrue     = cond_true_q;
  assign ctl.o_stackFull    = full;
  assign ctl.o_stackEmpty   = empty;
  assign ctl.o_stackError   = stack_error_q;

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboarded bench for flag_unit: directed scenarios plus random traffic,
// checked against a queue-based model of the flag register and stack.
module tb_flag_unit;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  wire  [7:0] bus_out;

  flag_unit_if bif ();

  flag_unit dut (
    .i_clk   (clk),
    .i_reset (rst),
    .ctl     (bif.slave),
    .i_bus   (bus_in),
    .o_bus   (bus_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {flags[3:0], cond_true, full, empty, error}
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_ct;
  logic       m_err;

  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] cc);
    logic n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cc)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return n;
      6: return !n;
      7: return v;
      8: return !v;
      9: return c & !z;
      10: return !c | z;
      11: return n == v;
      12: return n != v;
      13: return !z & (n == v);
      14: return z | (n != v);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] model_vec();
    return {m_flags, m_ct, (m_stack.size() == 4), (m_stack.size() == 0), m_err};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bif.o_flagNegative, bif.o_flagZero, bif.o_flagOverflow, bif.o_flagCarry,
            bif.o_condTrue, bif.o_stackFull, bif.o_stackEmpty, bif.o_stackError};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = 4'h0;
    m_stack.delete();
    m_ct  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic set_idle();
    bif.i_flagNegative    = 1'b0;
    bif.i_flagZero        = 1'b0;
    bif.i_flagOverflow    = 1'b0;
    bif.i_flagCarry       = 1'b0;
    bif.i_ctrlFlagsNWE    = 1'b1;
    bif.i_ctrlFlagsBusNWE = 1'b1;
    bif.i_ctrlFlagsNOE    = 1'b1;
    bif.i_ctrlPush        = 1'b0;
    bif.i_ctrlPop         = 1'b0;
    bif.i_ctrlEval        = 1'b0;
    bif.i_cond            = 4'h0;
    bus_in                = 8'h00;
  endtask

  // driver: apply one cycle of controls at negedge, predict the edge outcome
  task automatic step(input logic [3:0] alu, input logic nwe, input logic bus_nwe,
                      input logic [7:0] bus, input logic push, input logic pop,
                      input logic eval, input logic [3:0] cc);
    logic [3:0] old_flags;
    logic       popped;
    logic [3:0] pop_val;
    @(negedge clk);
    {bif.i_flagNegative, bif.i_flagZero, bif.i_flagOverflow, bif.i_flagCarry} = alu;
    bif.i_ctrlFlagsNWE    = nwe;
    bif.i_ctrlFlagsBusNWE = bus_nwe;
    bif.i_ctrlPush        = push;
    bif.i_ctrlPop         = pop;
    bif.i_ctrlEval        = eval;
    bif.i_cond            = cc;
    bus_in                = bus;
    old_flags = m_flags;
    popped  = 1'b0;
    pop_val = 4'h0;
    if (push && pop) m_err = 1'b1;
    else if (push) begin
      if (m_stack.size() == 4) m_err = 1'b1;
      else m_stack.push_back(old_flags);
    end else if (pop) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else begin
        popped  = 1'b1;
        pop_val = m_stack.pop_back();
      end
    end
    if (popped) m_flags = pop_val;
    else if (!bus_nwe) m_flags = bus[3:0];
    else if (!nwe) m_flags = alu;
    if (eval) m_ct = cond_ref(old_flags, cc);
    exp_q.push_back(model_vec());
  endtask

  task automatic idle_step();
    step(4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic bus_load(input logic [7:0] b);
    step(4'h0, 1'b1, 1'b0, b, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic eval_cond(input logic [3:0] cc);
    step(4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, cc);
  endtask

  // Reset pulse asserted between edges, held across one rising edge.
  task automatic async_reset(input string name);
    @(negedge clk);
    set_idle();
    bif.i_ctrlPush = 1'b1;
    bif.i_ctrlEval = 1'b1;
    bif.i_ctrlFlagsBusNWE = 1'b0;
    bus_in = 8'h0F;
    #2 rst = 1'b1;
    #1 check8(name, dut_vec(), 8'b0000_0010);
    model_reset();
    exp_q.push_back(model_vec());
    @(negedge clk);
    rst = 1'b0;
    set_idle();
  endtask

  // monitor: one registered result per rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check8("edge_state", dut_vec(), exp_q.pop_front());
    end
  end

  initial begin
    set_idle();
    model_reset();
    rst = 1'b1;
    #1 check8("reset_state", dut_vec(), 8'b0000_0010);
    #16 rst = 1'b0;

    // ALU load and bus drive
    step(4'b1010, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    bif.i_ctrlFlagsNOE = 1'b0;
    #1 check8("bus_drive", bus_out, 8'h0A);
    bif.i_ctrlFlagsNOE = 1'b1;
    #1;
    checks++;
    if (!(bus_out === 8'hzz || bus_out === 8'h00)) begin
      failures++;
      $display("FAIL bus_release: got %h expected zz", bus_out);
    end

    // push, overwrite, pop restores
    step(4'h0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    bus_load(8'h05);
    step(4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0);

    // fill, overflow, drain, underflow
    async_reset("reset_mid_a");
    for (int i = 0; i < 5; i++) begin
      bus_load(8'(i + 1));
      step(4'h0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    end
    for (int i = 0; i < 5; i++)
      step(4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0);

    // condition codes on N=1 Z=0 V=0 C=1
    bus_load(8'h09);
    eval_cond(4'd12);
    eval_cond(4'd11);
    eval_cond(4'd9);
    eval_cond(4'd15);
    eval_cond(4'd0);
    for (int cc = 0; cc < 16; cc++) eval_cond(4'(cc));

    // pop beats bus load; push+pop together
    async_reset("reset_mid_b");
    bus_load(8'h08);
    step(4'h0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    step(4'h0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 4'h0);
    bus_load(8'h06);
    step(4'h0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);
    step(4'h5, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0);

    // depth 3 with cond true, then asynchronous reset
    async_reset("reset_mid_c");
    for (int i = 0; i < 3; i++)
      step(4'(i + 7), 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0);
    async_reset("reset_mid_d");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
      if (i % 100 == 50) async_reset("reset_rand");
    end
    idle_step();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
